// File: rtl/blink_pkg.sv
// Shared types and helpers for the event blinker: FSM state encoding and
// a saturating increment for the pending-event counter.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Width-agnostic: callers zero-extend into 32 bits and truncate the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module blink_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/event_blinker.sv
// Renders single-cycle event strobes as fixed-length LED blinks, queueing
// events that arrive mid-blink in a saturating pending counter.
module event_blinker
    import blink_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    blink_state_t      state_q, state_d;
    logic              tmr_load, tmr_zero, consume;
    logic [TW-1:0]     tmr_val;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              led_q, busy_q, ovf_q, ovf_d;

    blink_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        consume  = 1'b0;
        case (state_q)
            IDLE: if (evt_in) begin
                state_d  = ON;
                tmr_load = 1'b1;
            end
            ON: if (tmr_zero) begin
                state_d  = OFF;
                tmr_load = 1'b1;
                tmr_val  = OFF_LOAD;
            end
            OFF: if (tmr_zero) begin
                if (pending_q != '0 || evt_in) begin
                    state_d  = ON;
                    tmr_load = 1'b1;
                    consume  = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A consume that coincides with an arrival nets to zero, even when saturated.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = 1'b0;
        if (state_q != IDLE) begin
            if (consume) begin
                if (!evt_in)
                    pending_d = pending_q - 1'b1;
            end else if (evt_in) begin
                if (pending_q == PEND_MAX)
                    ovf_d = 1'b1;
                else
                    pending_d = PEND_W'(sat_inc(32'(pending_q), 32'(PEND_MAX)));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            led_q     <= (state_d == ON);
            busy_q    <= (state_d != IDLE);
            ovf_q     <= ovf_d;
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = ovf_q;

endmodule

// File: doc/event_blinker.md
# event_blinker

Output-side companion to the button conditioning path. Takes single-cycle event pulses (such as the debounced button strobes) and renders each one as a visible LED blink of fixed on/off length. Events arriving during a blink are queued in a saturating pending counter so no press is visually lost. It sits between the event logic and the board LED pins.

## Interface

**Parameters**
- `ON_CYCLES`, default 25_000_000: cycles `led_out` is high per blink; must be ≥1.
- `OFF_CYCLES`, default 25_000_000: cycles `led_out` is low after each blink; must be ≥1.
- `PEND_W`, default 4: width of the pending-event counter; must be ≥1.

**Ports**
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `evt_in` input 1: event strobe, sampled every rising edge; each high cycle is one event.
- `led_out` output 1: blink output, registered.
- `busy` output 1: high while a blink (ON or OFF phase) is in progress, registered.
- `pending` output PEND_W: number of queued events not yet started.
- `overflow` output 1: one-cycle pulse when an event is dropped because `pending` is saturated.

## Operation

- **Reset values:** state IDLE; `led_out`=0, `busy`=0, `pending`=0, `overflow`=0; timer=0.
- **States:** IDLE, ON, OFF.
- **Timer:** width `$clog2(max(ON_CYCLES, OFF_CYCLES))`, minimum 1 bit; down-counts.
- **IDLE:**
  - With `evt_in`=1: go to ON, load timer=ON_CYCLES−1. `pending` is untouched.
- **ON:**
  - While timer≠0: decrement the timer.
  - At timer=0: go to OFF, load timer=OFF_CYCLES−1.
- **OFF:**
  - While timer≠0: decrement the timer.
  - At timer=0, if `pending`>0 or `evt_in`=1: go to ON, load timer=ON_CYCLES−1, consume one event.
  - At timer=0 otherwise: go to IDLE.
- **`evt_in` in ON/OFF:** increments `pending`, except in the cases below.
- **Simultaneous consume and arrival** (OFF→ON edge with `evt_in`=1): `pending` is unchanged, including when it is saturated. `overflow` stays 0.
- **Saturation:** `pending` saturates at 2^PEND_W−1.
  - An arrival when saturated and not simultaneously consuming is dropped.
  - `overflow`=1 for the following cycle.
- **Outputs:** `led_out` = (state==ON); `busy` = (state≠IDLE). Both are decoded from the registered state, with no combinational path from `evt_in`.
- **Reset mid-operation:** all state is cleared asynchronously. The LED goes dark immediately and queued events are discarded.

## Timing

- **Latency:** an event sampled at the edge ending cycle t gives `led_out` high in cycles t+1 … t+ON_CYCLES.
- **OFF phase:** `led_out` is low for cycles t+ON_CYCLES+1 … t+ON_CYCLES+OFF_CYCLES.
- **Back-to-back blinks:** the next ON phase starts in the cycle immediately after the last OFF cycle, with no idle gap.
- **Blink period:** exactly ON_CYCLES+OFF_CYCLES cycles.
- **`pending`:** reflects an increment or decrement in the cycle after the causing edge.
- **`overflow`:** high for exactly one cycle, the cycle after the dropped event.

## Structure

- **Shared package `blink_pkg`:**
  - State enum `blink_state_t` {IDLE, ON, OFF}.
  - Saturating-increment helper function for the pending counter.
- **Sub-module `blink_timer`:**
  - Loadable down-counter with `load`, `load_val`, and a `zero` flag, parameterised on width.
  - `event_blinker` instantiates it once.
  - The top level holds the FSM, the pending counter and the output registers.

## Test plan

Parameters for all scenarios: ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2.

- **Single event:** `evt_in` at cycle 10 → `led_out` high cycles 11–14, low 15–16; `busy` high 11–16, low from 17; `pending` stays 0.
- **Two adjacent events:** `evt_in` at cycles 10 and 11 → `pending`=1 at cycle 12; `led_out` high 11–14 and 17–20, low 15–16 and 21–22; `pending`=0 from 17; `busy` low from 23.
- **Saturation:** `evt_in` at cycles 10–14 → `pending` reaches 3 at cycle 14; event at 14 is dropped; `overflow` high only in cycle 15; exactly 4 blinks total, ending with `busy` low at cycle 35.
- **Coincident event:** `evt_in` at cycle 10, then at cycle 16 (last OFF cycle) → second ON runs 17–20 with no gap; `pending` stays 0 throughout.
- **Reset mid-blink:** events at 10, 11, 12, then `reset` asserted during cycle 13 → `led_out`, `busy` and `pending` are 0 immediately. `evt_in` at cycle 20 after release → fresh blink 21–24, `pending` 0.
